// File: rtl/uart_alu_interface_if.sv
// Signal bundle between the UART/ALU environment and the uart_alu_interface sequencer.
// master: environment side (uart_rx, ALU, uart_tx); slave: the sequencer itself.
interface uart_alu_interface_if #(
    parameter int DATA_BITS = 8,
    parameter int OP_BITS   = 6
);
    logic                 rx_done;
    logic [DATA_BITS-1:0] rx_data;
    logic [DATA_BITS-1:0] alu_result;
    logic                 tx_done;
    logic [DATA_BITS-1:0] alu_a;
    logic [DATA_BITS-1:0] alu_b;
    logic [OP_BITS-1:0]   alu_op;
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 busy;

    modport master (
        output rx_done, rx_data, alu_result, tx_done,
        input  alu_a, alu_b, alu_op, tx_start, tx_data, busy
    );

    modport slave (
        input  rx_done, rx_data, alu_result, tx_done,
        output alu_a, alu_b, alu_op, tx_start, tx_data, busy
    );
endinterface

// File: rtl/uart_alu_interface.sv
// Sequencer: collects A, B, opcode bytes from uart_rx, drives the ALU, sends the result to uart_tx.
// Optional macro UART_ALU_FLAGS_EN adds a second tx byte per command carrying {sign, 0..., zero}.
//
// state        | meaning
// WAIT_A       | idle, waiting for operand A byte
// WAIT_B       | waiting for operand B byte
// WAIT_OP      | waiting for opcode byte
// CALC         | one cycle for the ALU to settle
// SEND         | latch result into tx_data, pulse tx_start
// WAIT_TX      | waiting for uart_tx to finish the result byte
// WAIT_FLAGS   | waiting for uart_tx to finish the flags byte (UART_ALU_FLAGS_EN only)
module uart_alu_interface #(
    parameter int DATA_BITS = 8,
    parameter int OP_BITS   = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    uart_alu_interface_if.slave        bus
);

`ifdef UART_ALU_FLAGS_EN
    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX, WAIT_FLAGS
    } state_t;
`else
    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX
    } state_t;
`endif

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] alu_a_q, alu_a_d;
    logic [DATA_BITS-1:0] alu_b_q, alu_b_d;
    logic [OP_BITS-1:0]   alu_op_q, alu_op_d;
    logic                 tx_start_q, tx_start_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
`ifdef UART_ALU_FLAGS_EN
    logic [DATA_BITS-1:0] flags_q, flags_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
`ifdef UART_ALU_FLAGS_EN
            flags_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
`ifdef UART_ALU_FLAGS_EN
            flags_q    <= flags_d;
`endif
        end
    end

    // rx_done outside the three collect states is dropped on purpose: there is no command queue.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
`ifdef UART_ALU_FLAGS_EN
        flags_d    = flags_q;
`endif
        case (state_q)
            WAIT_A: if (bus.rx_done) begin
                alu_a_d = bus.rx_data;
                state_d = WAIT_B;
            end
            WAIT_B: if (bus.rx_done) begin
                alu_b_d = bus.rx_data;
                state_d = WAIT_OP;
            end
            WAIT_OP: if (bus.rx_done) begin
                alu_op_d = bus.rx_data[OP_BITS-1:0];
                state_d  = CALC;
            end
            CALC: state_d = SEND;
            SEND: begin
                tx_data_d  = bus.alu_result;
                tx_start_d = 1'b1;
`ifdef UART_ALU_FLAGS_EN
                flags_d    = {bus.alu_result[DATA_BITS-1], {(DATA_BITS-2){1'b0}},
                              (bus.alu_result == '0)};
`endif
                state_d    = WAIT_TX;
            end
`ifdef UART_ALU_FLAGS_EN
            WAIT_TX: if (bus.tx_done) begin
                tx_data_d  = flags_q;
                tx_start_d = 1'b1;
                state_d    = WAIT_FLAGS;
            end
            WAIT_FLAGS: if (bus.tx_done) state_d = WAIT_A;
`else
            WAIT_TX: if (bus.tx_done) state_d = WAIT_A;
`endif
            default: begin
                state_d    = WAIT_A;
                tx_start_d = 1'b0;
            end
        endcase
    end

    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_op   = alu_op_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = (state_q != WAIT_A);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface: behavioural ALU (ADD=0x20, SUB=0x22) and a uart_tx
// model answering tx_done ~100 cycles after each tx_start.
module tb_uart_alu_interface;
    localparam int DB = 8;
    localparam int OB = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_done = 1'b0;
    logic [DB-1:0] rx_data = '0;
    logic force_tx_done = 1'b0;
    logic model_tx_done = 1'b0;
    logic pending = 1'b0;
    int   tx_cnt = 0;
    int   ntx = 0;
    int   exp_tx = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_alu_interface_if #(.DATA_BITS(DB), .OP_BITS(OB)) bus ();

    uart_alu_interface #(.DATA_BITS(DB), .OP_BITS(OB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.rx_done = rx_done;
    assign bus.rx_data = rx_data;
    assign bus.tx_done = model_tx_done | force_tx_done;
    assign bus.alu_result = (bus.alu_op == 6'h20) ? bus.alu_a + bus.alu_b :
                            (bus.alu_op == 6'h22) ? bus.alu_a - bus.alu_b : '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // uart_tx model; also flags a second tx_start before the previous frame completed
    always @(posedge clk) begin
        model_tx_done <= 1'b0;
        if (reset) begin
            pending <= 1'b0;
        end else begin
            if (pending) begin
                if (tx_cnt == 1) begin
                    model_tx_done <= 1'b1;
                    pending       <= 1'b0;
                end else begin
                    tx_cnt <= tx_cnt - 1;
                end
            end
            if (bus.tx_start) begin
                ntx++;
                chk("tx_start_without_tx_done", {31'd0, pending}, 32'd0);
                pending <= 1'b1;
                tx_cnt  <= 100;
            end
        end
    end

    task automatic send_byte(input logic [DB-1:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_tx_done();
        int n = 0;
        while (bus.tx_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("tx_done_timeout", {31'd0, (n < 300)}, 32'd1);
    endtask

    task automatic finish_cmd(input logic [DB-1:0] res, input logic [DB-1:0] flg, input bit inject);
        @(negedge clk);
        chk("calc_tx_start", {31'd0, bus.tx_start}, 32'd0);
        chk("calc_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        chk("send_tx_start", {31'd0, bus.tx_start}, 32'd1);
        chk("send_tx_data", {24'd0, bus.tx_data}, {24'd0, res});
        exp_tx++;
        @(negedge clk);
        chk("pulse_width", {31'd0, bus.tx_start}, 32'd0);
        if (inject) begin
            send_byte(8'h77);
            chk("drop_busy", {31'd0, bus.busy}, 32'd1);
            chk("drop_tx_start", {31'd0, bus.tx_start}, 32'd0);
        end
        wait_tx_done();
        chk("tx_data_stable", {24'd0, bus.tx_data}, {24'd0, res});
        chk("busy_at_tx_done", {31'd0, bus.busy}, 32'd1);
`ifdef UART_ALU_FLAGS_EN
        @(negedge clk);
        chk("flags_tx_start", {31'd0, bus.tx_start}, 32'd1);
        chk("flags_tx_data", {24'd0, bus.tx_data}, {24'd0, flg});
        exp_tx++;
        @(negedge clk);
        chk("flags_pulse_width", {31'd0, bus.tx_start}, 32'd0);
        wait_tx_done();
`else
        chk("flags_unused", {24'd0, flg}, {24'd0, flg ^ 8'h00});
`endif
        @(negedge clk);
        chk("busy_fall", {31'd0, bus.busy}, 32'd0);
        chk("idle_tx_start", {31'd0, bus.tx_start}, 32'd0);
    endtask

    task automatic run_cmd(input logic [DB-1:0] a, input logic [DB-1:0] b, input logic [DB-1:0] op,
                           input logic [DB-1:0] res, input logic [DB-1:0] flg, input bit inject);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        chk("alu_a", {24'd0, bus.alu_a}, {24'd0, a});
        chk("alu_b", {24'd0, bus.alu_b}, {24'd0, b});
        chk("alu_op", {26'd0, bus.alu_op}, {26'd0, op[OB-1:0]});
        finish_cmd(res, flg, inject);
    endtask

    logic [DB-1:0] vec [4][5];

    initial begin
        vec[0] = '{8'h10, 8'h20, 8'h20, 8'h30, 8'h00};
        vec[1] = '{8'h80, 8'h01, 8'h22, 8'h7F, 8'h00};
        vec[2] = '{8'hFF, 8'h01, 8'h20, 8'h00, 8'h01};
        vec[3] = '{8'h00, 8'h01, 8'h22, 8'hFF, 8'h80};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_alu_a", {24'd0, bus.alu_a}, 32'd0);
        chk("rst_alu_b", {24'd0, bus.alu_b}, 32'd0);
        chk("rst_alu_op", {26'd0, bus.alu_op}, 32'd0);
        chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);

        // spurious tx_done in WAIT_A and WAIT_B, then the basic add command
        force_tx_done = 1'b1;
        @(negedge clk);
        force_tx_done = 1'b0;
        @(negedge clk);
        chk("spur_a_busy", {31'd0, bus.busy}, 32'd0);
        chk("spur_a_tx_start", {31'd0, bus.tx_start}, 32'd0);
        send_byte(8'h05);
        force_tx_done = 1'b1;
        @(negedge clk);
        force_tx_done = 1'b0;
        @(negedge clk);
        chk("spur_b_busy", {31'd0, bus.busy}, 32'd1);
        chk("spur_b_tx_start", {31'd0, bus.tx_start}, 32'd0);
        send_byte(8'h03);
        send_byte(8'h20);
        chk("add_alu_a", {24'd0, bus.alu_a}, 32'h05);
        chk("add_alu_b", {24'd0, bus.alu_b}, 32'h03);
        chk("add_alu_op", {26'd0, bus.alu_op}, 32'h20);
        finish_cmd(8'h08, 8'h00, 1'b0);

        // zero and negative results (flags bytes when enabled)
        run_cmd(8'h03, 8'h03, 8'h22, 8'h00, 8'h01, 1'b0);
        run_cmd(8'h01, 8'h02, 8'h22, 8'hFF, 8'h80, 1'b0);

        // byte arriving during WAIT_TX must be dropped
        run_cmd(8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 1'b1);
        run_cmd(8'h01, 8'h01, 8'h20, 8'h02, 8'h00, 1'b0);

        // reset after operand A
        send_byte(8'h44);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_alu_a", {24'd0, bus.alu_a}, 32'd0);
        chk("mid_rst_alu_b", {24'd0, bus.alu_b}, 32'd0);
        chk("mid_rst_alu_op", {26'd0, bus.alu_op}, 32'd0);
        chk("mid_rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        run_cmd(8'h10, 8'h01, 8'h20, 8'h11, 8'h00, 1'b0);

        // back-to-back commands
        for (int i = 0; i < 4; i++)
            run_cmd(vec[i][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4], 1'b0);

        repeat (5) @(negedge clk);
        chk("tx_start_count", ntx, exp_tx);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
